// File: rtl/cle_pkg.sv
// Shared types and geometry for the component labeling engine.
// Used by the pixel fetch stage and the labeler.
package cle_pkg;

  localparam int IMG_W        = 32;
  localparam int IMG_H        = 32;
  localparam int ROM_AW       = 7;
  localparam int SRAM_AW      = 10;
  localparam int PIX_PER_BYTE = 8;
  localparam int BUF_D        = 2;
  localparam int CNT_W        = $clog2(BUF_D + 1);
  localparam int CRD_W        = $clog2(IMG_W);

  typedef logic [CRD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ROM_AW-1:0] ROM_LAST =
    ROM_AW'(IMG_W * IMG_H / PIX_PER_BYTE - 1);
  localparam coord_t COL_MAX = coord_t'(IMG_W - 1);
  localparam coord_t ROW_MAX = coord_t'(IMG_H - 1);

endpackage

// File: rtl/cle_pixel_fetch_if.sv
// Raster pixel stream between fetch stage and labeler.
// Valid/ready handshake with row/col tags.
interface cle_pixel_fetch_if;
  import cle_pkg::*;

  logic   pix_valid;
  logic   pix_ready;
  logic   pix_bit;
  coord_t pix_row;
  coord_t pix_col;
  logic   pix_last;

  modport master (
    output pix_valid,
    output pix_bit,
    output pix_row,
    output pix_col,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_bit,
    input  pix_row,
    input  pix_col,
    input  pix_last,
    output pix_ready
  );

endinterface

// File: rtl/cle_byte_fifo.sv
// Small byte prefetch FIFO with push/pop/count.
// Caller never pushes when full unless popping in the same cycle.
module cle_byte_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wp_q] = din;
      wp_d        = nxt(wp_q);
    end
    if (pop) begin
      rp_d = nxt(rp_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/cle_pixel_fetch.sv
// Reads the packed binary image from ROM and unpacks it
// into a raster pixel stream, one pixel per clock unstalled.
module cle_pixel_fetch
  import cle_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [7:0]        rom_q,
  cle_pixel_fetch_if.master pix,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic [ROM_AW-1:0]  rom_a_q, rom_a_d;
  logic               rd_inflight_q, rd_inflight_d;
  coord_t             row_q, row_d;
  coord_t             col_q, col_d;

  logic               issue;
  logic               fire;
  logic               pop;
  logic               valid;
  logic               last;
  logic [7:0]         head;
  logic [CNT_W-1:0]   fifo_cnt;

  // rom_q is only meaningful the cycle after a read was issued
  cle_byte_fifo #(
    .DEPTH (BUF_D),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rd_inflight_q),
    .din   (rom_q),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt)
  );

  assign busy  = (state_q == FETCH) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign valid = busy && (fifo_cnt != '0);
  assign last  = valid && (row_q == ROW_MAX)
                       && (col_q == COL_MAX);
  assign fire  = valid && pix.pix_ready;
  assign pop   = fire && (col_q[2:0] == 3'd7);
  assign issue = (state_q == FETCH) &&
    ((32'(fifo_cnt) + 32'(rd_inflight_q)) < 32'(BUF_D));

  always_comb begin
    state_d       = state_q;
    rom_a_d       = rom_a_q;
    row_d         = row_q;
    col_d         = col_q;
    rd_inflight_d = issue;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          rom_a_d = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FETCH: begin
        if (issue) begin
          if (rom_a_q == ROM_LAST) state_d = DRAIN;
          else rom_a_d = rom_a_q + ROM_AW'(1);
        end
      end
      DRAIN: ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fire) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + coord_t'(1);
      end else begin
        col_d = col_q + coord_t'(1);
      end
      if (last) begin
        state_d = DONE;
        row_d   = '0;
        col_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rom_a_q       <= '0;
      rd_inflight_q <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
    end else begin
      state_q       <= state_d;
      rom_a_q       <= rom_a_d;
      rd_inflight_q <= rd_inflight_d;
      row_q         <= row_d;
      col_q         <= col_d;
    end
  end

  assign rom_a         = rom_a_q;
  assign pix.pix_valid = valid;
  assign pix.pix_bit   = valid & head[3'd7 - col_q[2:0]];
  assign pix.pix_row   = row_q;
  assign pix.pix_col   = col_q;
  assign pix.pix_last  = last;

endmodule
